uart_rx_frame_check: RTL and testbench
======================================

# uart_rx_frame_check

Parametrised UART RX frame checker: the successor of the single-purpose start-bit checker. It consumes one sampled bit per bit period from the RX oversampling sampler and tracks frame position (start, data, optional parity, stop). It assembles the data word and reports start glitch, parity error and stop (framing) error. It sits between the RX sampler/edge counter and the RX FSM/output register; the RX FSM only has to issue `frame_start` and consume the result strobes.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal 5..9.
- `STOP_BITS`, 1: stop bits checked, legal 1..2.

- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse; a falling edge was detected, so a frame begins.
- `bit_valid`  in  1: one-cycle strobe; `sampled_bit` holds the final sampled value for the current bit period.
- `sampled_bit`  in  1: sampled serial bit.
- `par_en`  in  1: parity bit present in frame.
- `par_typ`  in  1: 0 = even, 1 = odd.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).
- `rx_data`  out  DATA_WIDTH: last accepted data word, LSB first on the line.
- `data_valid`  out  1: one-cycle pulse; `rx_data` was updated with an error-free frame.
- `strt_glitch`  out  1: one-cycle pulse; the start bit sampled high.
- `par_err`  out  1: one-cycle pulse at end of frame; parity mismatch.
- `stop_err`  out  1: one-cycle pulse at end of frame; a stop bit sampled low.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `frame_start` moves to START. On that same cycle, `par_en` and `par_typ` are latched for the whole frame. `bit_valid` is ignored in IDLE.
- **START:** on `bit_valid`:
  - If `sampled_bit`=1, pulse `strt_glitch` and return to IDLE. No other flag fires.
  - Otherwise go to DATA and clear the bit counter and the parity accumulator.
- **DATA:** each `bit_valid` does the following:
  - Right-shifts `sampled_bit` into the shift register MSB, so the first bit received ends in bit 0.
  - XORs `sampled_bit` into the parity accumulator.
  - Increments the counter, which is `$clog2(DATA_WIDTH+1)` bits wide.
  - After the DATA_WIDTH-th bit, the next state is PARITY if the latched `par_en` is set, else STOP.
- **PARITY:** on `bit_valid`, compute expected = accumulator XOR latched `par_typ`. Record a mismatch with `sampled_bit` in an internal sticky bit, then go to STOP.
- **STOP:** each `bit_valid` ORs `~sampled_bit` into a sticky stop-error bit. After STOP_BITS strobes, the end-of-frame evaluation runs and the state returns to IDLE:
  - `par_err` equals the parity sticky bit.
  - `stop_err` equals the stop sticky bit.
  - `data_valid` plus an `rx_data` update happen only if both sticky bits are 0.
- `rx_data` is never updated by a frame with any error; it holds the previous value.
- `frame_start` while `busy` is ignored; the current frame continues.
- `bit_valid` and `frame_start` in the same IDLE cycle: the frame starts and the bit is not consumed.
- Sticky bits are cleared on entry to START.

## Timing
- All outputs are registered.
- Result pulses (`strt_glitch`, `par_err`, `stop_err`, `data_valid`) assert in the cycle after the `clk` edge that samples the deciding `bit_valid`. They last exactly one cycle.
- `par_err` and `stop_err` can assert together; `data_valid` is then 0.
- `busy` rises in the cycle after `frame_start`. It falls together with the end-of-frame pulse, or with `strt_glitch`.
- Back-to-back frames: `frame_start` is accepted in the first cycle `busy`=0.
- Reset values: state IDLE, counter 0, sticky bits 0, all outputs 0, `rx_data` = 0.
- `rst` mid-frame forces IDLE on the next edge. The partial frame is discarded and no flag pulses.

## Structure
- Shared package `uart_rx_pkg`:
  - State enum `rx_chk_state_e` (IDLE, START, DATA, PARITY, STOP).
  - Parity constants `PAR_EVEN`=1'b0 and `PAR_ODD`=1'b1.
  - Legal-range checks for DATA_WIDTH and STOP_BITS, as elaboration-time assertions.
- One natural sub-module: `frame_parity_acc`. It is a clear/enable XOR accumulator with a parity-type input and an expected-parity output, reused later by the TX parity generator.
- Everything else (FSM, counter, shift register, sticky bits) lives in the top module.

## Test plan
- DATA_WIDTH=8, `par_en`=0, STOP_BITS=1: frame start 0, data 0xA5 LSB first, stop 1 -> `data_valid` one cycle, `rx_data`=0xA5, no error flags.
- Start bit sampled 1 -> `strt_glitch` one cycle. No `data_valid`, `busy` falls, `rx_data` unchanged. The next `frame_start` is accepted.
- `par_en`=1, `par_typ`=0 (even), data 0x03: parity bit 0 -> clean frame. Same frame with parity bit 1 -> `par_err`, no `data_valid`, `rx_data` holds the prior value.
- STOP_BITS=2, data 0x5A: stop bits 1,0 -> `stop_err` only. Parity error plus stop bit 0 in the same frame -> `par_err` and `stop_err` assert in the same cycle.
- `frame_start` asserted mid-DATA, and `bit_valid` coincident with `frame_start` in IDLE -> both ignored. The frame decodes correctly with a bit count of exactly 8.
- `rst` asserted for one cycle after 4 data bits -> IDLE, all outputs 0, no flag pulses. A following full frame 0xFF decodes with `data_valid`.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame path.
//   rx_chk_state_e : frame-position FSM states of the RX frame checker
//   PAR_EVEN/ODD   : encoding of the par_typ input
//   *_ok functions : legal-range checks used for elaboration-time assertions
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_chk_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  function automatic bit data_width_ok(input int dw);
    return (dw >= DATA_WIDTH_MIN) && (dw <= DATA_WIDTH_MAX);
  endfunction

  function automatic bit stop_bits_ok(input int sb);
    return (sb >= STOP_BITS_MIN) && (sb <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/frame_parity_acc.sv
// Clear/enable XOR accumulator with parity-type selection.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the accumulator (wins over en)
//   en, din   : XOR din into the accumulator when en is high
//   par_typ   : PAR_EVEN / PAR_ODD
//   expected  : parity bit that makes the frame match par_typ
module frame_parity_acc
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  input  logic par_typ,
  output logic expected
);

  logic acc;

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= 1'b0;
    else if (en)    acc <= acc ^ din;
  end

  // Even parity: bit equals XOR of data. Odd parity: its complement.
  assign expected = acc ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: tracks start/data/parity/stop position from one
// sampled bit per bit period, assembles the data word and flags errors.
//   clk, rst       : clock, synchronous active-high reset
//   frame_start    : falling edge seen, frame begins (ignored while busy)
//   bit_valid      : sampled_bit holds the value for the current bit period
//   sampled_bit    : serial bit
//   par_en/par_typ : parity present / odd(1) or even(0); latched at frame start
//   busy           : frame in progress
//   rx_data        : last error-free data word (first received bit in bit 0)
//   data_valid     : pulse, rx_data updated
//   strt_glitch    : pulse, start bit sampled high
//   par_err        : pulse at end of frame, parity mismatch
//   stop_err       : pulse at end of frame, a stop bit sampled low
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stop_err
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_dw
    $error("uart_rx_frame_check: DATA_WIDTH must be 5..9");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_bad_sb
    $error("uart_rx_frame_check: STOP_BITS must be 1..2");
  end

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  rx_chk_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  par_en_q, par_typ_q;
  logic                  par_bad_q, stop_bad_q;
  logic                  par_expected;

  logic latch_cfg, cnt_clr, cnt_inc, acc_clr, acc_en, shift_en;
  logic set_par_bad, set_stop_bad, glitch_d, end_frame;
  logic stop_bad_final;

  frame_parity_acc u_par (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .din      (sampled_bit),
    .par_typ  (par_typ_q),
    .expected (par_expected)
  );

  always_comb begin
    state_d      = state_q;
    latch_cfg    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    shift_en     = 1'b0;
    set_par_bad  = 1'b0;
    set_stop_bad = 1'b0;
    glitch_d     = 1'b0;
    end_frame    = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        state_d   = START;
        latch_cfg = 1'b1;
      end
      START: if (bit_valid) begin
        if (sampled_bit) begin
          glitch_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = DATA;
          cnt_clr = 1'b1;
          acc_clr = 1'b1;
        end
      end
      DATA: if (bit_valid) begin
        shift_en = 1'b1;
        acc_en   = 1'b1;
        if (cnt_q == LAST_DATA) begin
          // counter is reused to count stop bits
          cnt_clr = 1'b1;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PARITY: if (bit_valid) begin
        set_par_bad = (sampled_bit != par_expected);
        state_d     = STOP;
      end
      STOP: if (bit_valid) begin
        set_stop_bad = ~sampled_bit;
        if (cnt_q == LAST_STOP) begin
          end_frame = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the final stop bit must count toward this frame's verdict
  assign stop_bad_final = stop_bad_q | set_stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
      par_bad_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);

      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;

      if (shift_en) shreg_q <= {sampled_bit, shreg_q[DATA_WIDTH-1:1]};

      if (latch_cfg) begin
        par_en_q   <= par_en;
        par_typ_q  <= par_typ;
        par_bad_q  <= 1'b0;
        stop_bad_q <= 1'b0;
      end else begin
        if (set_par_bad)  par_bad_q  <= 1'b1;
        if (set_stop_bad) stop_bad_q <= 1'b1;
      end

      strt_glitch <= glitch_d;
      par_err     <= end_frame & par_bad_q;
      stop_err    <= end_frame & stop_bad_final;
      data_valid  <= end_frame & ~par_bad_q & ~stop_bad_final;
      if (end_frame && !par_bad_q && !stop_bad_final) rx_data <= shreg_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench: u1 has one stop bit, u2 has two; both share stimulus.
module tb_uart_rx_frame_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0, bit_valid = 1'b0, sampled_bit = 1'b1;
  logic par_en = 1'b0, par_typ = 1'b0;

  logic       busy1, dv1, gl1, pe1, se1;
  logic [7:0] rx1;
  logic       busy2, dv2, gl2, pe2, se2;
  logic [7:0] rx2;

  int n_cmp = 0, n_bad = 0;
  int pc_dv1 = 0, pc_gl1 = 0, pc_pe1 = 0, pc_se1 = 0;
  int pc_dv2 = 0, pc_pe2 = 0, pc_se2 = 0;
  logic [31:0] base;

  wire [4:0] st1 = {busy1, dv1, gl1, pe1, se1};
  wire [4:0] st2 = {busy2, dv2, gl2, pe2, se2};

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .busy(busy1), .rx_data(rx1), .data_valid(dv1), .strt_glitch(gl1),
    .par_err(pe1), .stop_err(se1));

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .busy(busy2), .rx_data(rx2), .data_valid(dv2), .strt_glitch(gl2),
    .par_err(pe2), .stop_err(se2));

  always #5 clk = ~clk;

  // pulse counters: a pulse lasting more than one cycle counts more than once
  always @(posedge clk) begin
    pc_dv1 <= pc_dv1 + int'(dv1);
    pc_gl1 <= pc_gl1 + int'(gl1);
    pc_pe1 <= pc_pe1 + int'(pe1);
    pc_se1 <= pc_se1 + int'(se1);
    pc_dv2 <= pc_dv2 + int'(dv2);
    pc_pe2 <= pc_pe2 + int'(pe2);
    pc_se2 <= pc_se2 + int'(se2);
  end

  function automatic logic [31:0] cnt1();
    return {8'(pc_dv1), 8'(pc_gl1), 8'(pc_pe1), 8'(pc_se1)};
  endfunction
  function automatic logic [31:0] cnt2();
    return {8'(pc_dv2), 8'h00, 8'(pc_pe2), 8'(pc_se2)};
  endfunction

  task automatic pulse_start();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) begin bit_valid = 1'b1; sampled_bit = b; end
    @(negedge clk) begin bit_valid = 1'b0; sampled_bit = 1'b1; end
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({st1, rx1} !== 13'h0) begin n_bad++;
      $display("FAIL reset_u1: got %h expected 0", {st1, rx1}); end
    n_cmp++; if ({st2, rx2} !== 13'h0) begin n_bad++;
      $display("FAIL reset_u2: got %h expected 0", {st2, rx2}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_clean();
    par_en = 1'b0;
    base = cnt1();
    pulse_start();
    n_cmp++; if (st1 !== 5'b10000) begin n_bad++;
      $display("FAIL clean_busy_rise: got %b expected 10000", st1); end
    send_bit(1'b0); send_data(8'hA5); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'hA5}) begin n_bad++;
      $display("FAIL clean_end: got %b/%h expected 01000/a5", st1, rx1); end
    @(negedge clk);
    n_cmp++; if (st1 !== 5'b00000) begin n_bad++;
      $display("FAIL clean_pulse_width: got %b expected 00000", st1); end
    settle();
    n_cmp++; if (cnt1() - base !== 32'h01000000) begin n_bad++;
      $display("FAIL clean_pulses: got %h expected 01000000", cnt1() - base); end
  endtask

  task automatic test_glitch();
    base = cnt1();
    pulse_start();
    send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b00100, 8'hA5}) begin n_bad++;
      $display("FAIL glitch: got %b/%h expected 00100/a5", st1, rx1); end
    pulse_start();
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++;
      $display("FAIL glitch_restart: got busy %b expected 1", busy1); end
    send_bit(1'b0); send_data(8'h3C); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'h3C}) begin n_bad++;
      $display("FAIL glitch_next_frame: got %b/%h expected 01000/3c", st1, rx1); end
    settle();
    n_cmp++; if (cnt1() - base !== 32'h01010000) begin n_bad++;
      $display("FAIL glitch_pulses: got %h expected 01010000", cnt1() - base); end
  endtask

  task automatic test_parity();
    par_en = 1'b1; par_typ = 1'b0;
    base = cnt1();
    pulse_start(); send_bit(1'b0); send_data(8'h03); send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'h03}) begin n_bad++;
      $display("FAIL par_even_ok: got %b/%h expected 01000/03", st1, rx1); end
    pulse_start(); send_bit(1'b0); send_data(8'h03); send_bit(1'b1); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b00010, 8'h03}) begin n_bad++;
      $display("FAIL par_even_bad: got %b/%h expected 00010/03", st1, rx1); end
    // odd parity, 0x07 has three ones -> parity bit 0; par_en dropped
    // mid-frame must not remove the parity slot
    par_typ = 1'b1;
    pulse_start();
    par_en = 1'b0; par_typ = 1'b0;
    send_bit(1'b0); send_data(8'h07); send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'h07}) begin n_bad++;
      $display("FAIL par_odd_latched: got %b/%h expected 01000/07", st1, rx1); end
    settle();
    n_cmp++; if (cnt1() - base !== 32'h02000100) begin n_bad++;
      $display("FAIL par_pulses: got %h expected 02000100", cnt1() - base); end
  endtask

  task automatic test_stop2();
    pulse_rst();
    par_en = 1'b0; par_typ = 1'b0;
    base = cnt2();
    pulse_start(); send_bit(1'b0); send_data(8'h5A); send_bit(1'b1);
    n_cmp++; if (st2 !== 5'b10000) begin n_bad++;
      $display("FAIL stop2_mid: got %b expected 10000", st2); end
    send_bit(1'b0);
    n_cmp++; if ({st2, rx2} !== {5'b00001, 8'h00}) begin n_bad++;
      $display("FAIL stop2_err: got %b/%h expected 00001/00", st2, rx2); end
    pulse_start(); send_bit(1'b0); send_data(8'h5A); send_bit(1'b1); send_bit(1'b1);
    n_cmp++; if ({st2, rx2} !== {5'b01000, 8'h5A}) begin n_bad++;
      $display("FAIL stop2_ok: got %b/%h expected 01000/5a", st2, rx2); end
    par_en = 1'b1;
    pulse_start(); send_bit(1'b0); send_data(8'h5A); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    n_cmp++; if ({st2, rx2} !== {5'b00011, 8'h5A}) begin n_bad++;
      $display("FAIL stop2_both: got %b/%h expected 00011/5a", st2, rx2); end
    par_en = 1'b0;
    settle();
    n_cmp++; if (cnt2() - base !== 32'h01000102) begin n_bad++;
      $display("FAIL stop2_pulses: got %h expected 01000102", cnt2() - base); end
  endtask

  task automatic test_ignored();
    pulse_rst();
    base = cnt1();
    // start and a high bit in the same IDLE cycle: the bit must not be
    // taken as the start bit
    @(negedge clk) begin frame_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1; end
    @(negedge clk) begin frame_start = 1'b0; bit_valid = 1'b0; end
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    pulse_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'h96}) begin n_bad++;
      $display("FAIL ignored_frame: got %b/%h expected 01000/96", st1, rx1); end
    settle();
    n_cmp++; if (cnt1() - base !== 32'h01000000) begin n_bad++;
      $display("FAIL ignored_pulses: got %h expected 01000000", cnt1() - base); end
  endtask

  task automatic test_reset_mid();
    base = cnt1();
    pulse_start(); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    pulse_rst();
    n_cmp++; if ({st1, rx1} !== 13'h0) begin n_bad++;
      $display("FAIL rst_mid: got %b/%h expected 00000/00", st1, rx1); end
    settle();
    n_cmp++; if (cnt1() - base !== 32'h0) begin n_bad++;
      $display("FAIL rst_mid_pulses: got %h expected 0", cnt1() - base); end
    pulse_start(); send_bit(1'b0); send_data(8'hFF); send_bit(1'b1);
    n_cmp++; if ({st1, rx1} !== {5'b01000, 8'hFF}) begin n_bad++;
      $display("FAIL rst_then_ff: got %b/%h expected 01000/ff", st1, rx1); end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_parity();
    test_stop2();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
